ladybird_bus_arbiter: RTL and testbench

Two-requester arbiter that lets the core's instruction-fetch port and data (MMU) port share a single memory port. It arbitrates requests round-robin, forwards the winner's address, write data and strobe, and records each accepted transaction's owner in an in-order tag FIFO. Memory responses are routed back to the issuing requester. It sits between the core/MMU and the single-ported memory or bus bridge.

---
 rtl/ladybird_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_ladybird_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_bus_arbiter.sv
`default_nettype none
// ============================================================================
// ladybird_bus_arbiter - round-robin fetch/data arbiter with in-order tag FIFO
// Revision 1.0
// ============================================================================
module ladybird_bus_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst,
  input  logic [1:0]        r_req,
  output logic [1:0]        r_gnt,
  input  logic [XLEN-1:0]   r_addr0,
  input  logic [XLEN-1:0]   r_addr1,
  input  logic [XLEN-1:0]   r_wdata0,
  input  logic [XLEN-1:0]   r_wdata1,
  input  logic [XLEN/8-1:0] r_wstrb0,
  input  logic [XLEN/8-1:0] r_wstrb1,
  output logic [1:0]        r_rvalid,
  output logic [XLEN-1:0]   r_rdata,
  output logic              m_req,
  input  logic              m_gnt,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_wstrb,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              err
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);

  logic             r_sel;
  logic             r_lock;
  logic             r_prio;
  logic             r_err;
  logic [DEPTH-1:0] r_tags;
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_cnt;

  logic w_run;
  logic w_sel;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_orphan;
  logic w_head;

  function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Outputs are forced quiet for the whole time either reset is asserted.
  assign w_run = anrst & nrst;

  always_comb begin
    w_sel = r_sel;
    if (!r_lock) begin
      case (r_req)
        2'b01:   w_sel = 1'b0;
        2'b10:   w_sel = 1'b1;
        2'b11:   w_sel = ~r_prio;
        default: w_sel = r_sel;
      endcase
    end
  end

  assign w_full   = (r_cnt == c_FULL);
  assign w_empty  = (r_cnt == '0);
  assign m_req    = w_run & r_req[w_sel] & ~w_full;
  assign w_push   = m_req & m_gnt;
  assign w_pop    = w_run & m_rvalid & ~w_empty;
  assign w_orphan = w_run & m_rvalid & w_empty;
  assign w_head   = r_tags[r_rd_ptr];

  assign m_addr   = w_sel ? r_addr1  : r_addr0;
  assign m_wdata  = w_sel ? r_wdata1 : r_wdata0;
  assign m_wstrb  = w_sel ? r_wstrb1 : r_wstrb0;

  assign r_gnt    = w_push ? (w_sel  ? 2'b10 : 2'b01) : 2'b00;
  assign r_rvalid = w_pop  ? (w_head ? 2'b10 : 2'b01) : 2'b00;
  assign r_rdata  = m_rdata;
  assign err      = r_err;

  // Tag storage needs no reset: an entry is only read after it was pushed.
  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= w_sel;
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_sel    <= 1'b0;
      r_lock   <= 1'b0;
      r_prio   <= 1'b1;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (!nrst) begin
      r_sel    <= 1'b0;
      r_lock   <= 1'b0;
      r_prio   <= 1'b1;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_sel <= w_sel;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
        r_prio   <= w_sel;
        r_lock   <= 1'b0;
      end else if (m_req) begin
        r_lock   <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_orphan) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ladybird_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ladybird_bus_arbiter - directed + random bench against a queue-based model
// Revision 1.0
// ============================================================================
module tb_ladybird_bus_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int SW    = XLEN / 8;

  logic            clk;
  logic            anrst;
  logic            nrst;
  logic [1:0]      r_req;
  logic [1:0]      r_gnt;
  logic [XLEN-1:0] r_addr0, r_addr1, r_wdata0, r_wdata1;
  logic [SW-1:0]   r_wstrb0, r_wstrb1;
  logic [1:0]      r_rvalid;
  logic [XLEN-1:0] r_rdata;
  logic            m_req;
  logic            m_gnt;
  logic [XLEN-1:0] m_addr, m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_rvalid;
  logic [XLEN-1:0] m_rdata;
  logic            err;

  ladybird_bus_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .anrst(anrst), .nrst(nrst),
    .r_req(r_req), .r_gnt(r_gnt),
    .r_addr0(r_addr0), .r_addr1(r_addr1),
    .r_wdata0(r_wdata0), .r_wdata1(r_wdata1),
    .r_wstrb0(r_wstrb0), .r_wstrb1(r_wstrb1),
    .r_rvalid(r_rvalid), .r_rdata(r_rdata),
    .m_req(m_req), .m_gnt(m_gnt),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: owners of outstanding transactions in acceptance order.
  bit         q[$];
  bit         md_prio;
  bit         md_locked;
  bit         md_lsel;
  bit         md_err;
  logic [1:0] last_gnt;

  task automatic model_reset();
    q.delete();
    md_prio   = 1'b1;
    md_locked = 1'b0;
    md_lsel   = 1'b0;
    md_err    = 1'b0;
  endtask

  task automatic cycle();
    bit sel, full, mreq, acc, pop, orphan;
    logic [1:0] eg, erv;
    @(negedge clk);
    if (!anrst || !nrst) begin
      check_eq("rst_m_req", 64'(m_req), 64'(0));
      check_eq("rst_r_gnt", 64'(r_gnt), 64'(0));
      check_eq("rst_r_rvalid", 64'(r_rvalid), 64'(0));
      last_gnt = 2'b00;
      @(posedge clk);
      model_reset();
      #1;
      return;
    end
    if (md_locked)           sel = md_lsel;
    else if (r_req == 2'b01) sel = 1'b0;
    else if (r_req == 2'b10) sel = 1'b1;
    else                     sel = !md_prio;
    full   = (q.size() == DEPTH);
    mreq   = r_req[sel] && !full;
    acc    = mreq && m_gnt;
    pop    = m_rvalid && (q.size() > 0);
    orphan = m_rvalid && (q.size() == 0);
    eg     = acc ? (2'b01 << sel) : 2'b00;
    erv    = pop ? (2'b01 << q[0]) : 2'b00;
    last_gnt = eg;
    check_eq("m_req", 64'(m_req), 64'(mreq));
    check_eq("r_gnt", 64'(r_gnt), 64'(eg));
    check_eq("r_rvalid", 64'(r_rvalid), 64'(erv));
    check_eq("err", 64'(err), 64'(md_err));
    if (mreq) begin
      check_eq("m_addr", 64'(m_addr), 64'(sel ? r_addr1 : r_addr0));
      check_eq("m_wdata", 64'(m_wdata), 64'(sel ? r_wdata1 : r_wdata0));
      check_eq("m_wstrb", 64'(m_wstrb), 64'(sel ? r_wstrb1 : r_wstrb0));
    end
    if (pop) check_eq("r_rdata", 64'(r_rdata), 64'(m_rdata));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (orphan) md_err = 1'b1;
    if (acc) begin
      q.push_back(sel);
      md_prio   = sel;
      md_locked = 1'b0;
    end else if (mreq) begin
      md_locked = 1'b1;
      md_lsel   = sel;
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic g, input logic rv, input int n);
    for (int k = 0; k < n; k++) begin
      r_req    = req;
      m_gnt    = g;
      m_rvalid = rv;
      m_rdata  = XLEN'($urandom);
      cycle();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && q.size() > 0; k++) drive(2'b00, 1'b0, 1'b1, 1);
    m_rvalid = 1'b0;
  endtask

  bit              pend[2];
  logic [XLEN-1:0] ra[2], rw[2];
  logic [SW-1:0]   rs[2];

  initial begin
    anrst = 1'b0; nrst = 1'b1;
    r_req = 2'b00; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    r_addr0 = '0; r_addr1 = '0; r_wdata0 = '0; r_wdata1 = '0;
    r_wstrb0 = '0; r_wstrb1 = '0;
    model_reset();
    last_gnt = 2'b00;
    drive(2'b00, 1'b0, 1'b0, 2);
    anrst = 1'b1;

    // Idle, then a single fetch and its response.
    drive(2'b00, 1'b1, 1'b0, 1);
    r_addr0 = 32'h100;
    drive(2'b01, 1'b1, 1'b0, 1);
    r_req = 2'b00; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    cycle();
    m_rvalid = 1'b0;

    // Round-robin under continuous contention.
    anrst = 1'b0; drive(2'b00, 1'b0, 1'b0, 1); anrst = 1'b1;
    r_addr1 = 32'h180;
    drive(2'b11, 1'b1, 1'b0, 1);
    drive(2'b11, 1'b1, 1'b1, 3);
    drain();

    // Stall lock, then fill the FIFO and exercise full / simultaneous push-pop.
    r_addr0 = 32'h300;
    drive(2'b01, 1'b0, 1'b0, 3);
    drive(2'b11, 1'b0, 1'b0, 1);
    drive(2'b11, 1'b1, 1'b0, 1);
    drive(2'b10, 1'b1, 1'b0, 1);
    drive(2'b01, 1'b1, 1'b0, 1);
    drive(2'b01, 1'b1, 1'b1, 1);
    drive(2'b01, 1'b1, 1'b1, 1);
    drain();

    // Write from the data port.
    r_addr1 = 32'h200; r_wdata1 = 32'hAB; r_wstrb1 = 4'b0001;
    drive(2'b10, 1'b1, 1'b0, 1);
    drain();
    r_wstrb1 = '0;

    // Orphan response sets sticky err.
    drive(2'b00, 1'b0, 1'b1, 1);
    drive(2'b00, 1'b0, 1'b0, 2);

    // Async reset with two transactions outstanding.
    drive(2'b01, 1'b1, 1'b0, 1);
    drive(2'b10, 1'b1, 1'b0, 1);
    #2 anrst = 1'b0;
    drive(2'b11, 1'b1, 1'b0, 1);
    anrst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1);

    // Randomised traffic with requesters that hold until granted.
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 600; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i] = 1'b1;
          ra[i] = XLEN'($urandom);
          rw[i] = XLEN'($urandom);
          rs[i] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
        end
      end
      r_req    = {pend[1], pend[0]};
      r_addr0  = ra[0]; r_wdata0 = rw[0]; r_wstrb0 = rs[0];
      r_addr1  = ra[1]; r_wdata1 = rw[1]; r_wstrb1 = rs[1];
      m_gnt    = ($urandom_range(0, 99) < 70);
      m_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rdata  = XLEN'($urandom);
      if (it == 250) nrst = 1'b0;
      if (it == 450) #2 anrst = 1'b0;
      cycle();
      nrst  = 1'b1;
      anrst = 1'b1;
      for (int i = 0; i < 2; i++) if (last_gnt[i]) pend[i] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
